// File: rtl/pll_reset_sequencer_if.sv
// Handshake bundle between the PLL reset sequencer and its environment.
interface pll_reset_sequencer_if;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_areset;
    logic       sys_reset;
    logic       running;
    logic [7:0] relock_count;
    logic [7:0] timeout_count;

    modport master (
        output pll_locked, relock_req,
        input  pll_areset, sys_reset, running, relock_count, timeout_count
    );

    modport slave (
        input  pll_locked, relock_req,
        output pll_areset, sys_reset, running, relock_count, timeout_count
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Brings the system PLL out of reset, qualifies its lock and holds the system
// in reset until lock has been stable; re-sequences on lock loss or request.
module pll_reset_sequencer #(
    parameter int unsigned PLL_RESET_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT       = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    pll_reset_sequencer_if.slave  bus
);
    localparam int unsigned MAX_A   = (PLL_RESET_CYCLES > LOCK_TIMEOUT) ? PLL_RESET_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_CYC = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RESET_PLL = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_sync1;
    logic             r_locked_s;
    logic             r_pll_areset;
    logic             r_sys_reset;
    logic             r_running;
    logic [7:0]       r_relock_count;
    logic [7:0]       r_timeout_count;
    logic             w_pll_areset_nxt;
    logic             w_sys_reset_nxt;
    logic             w_running_nxt;
    logic [7:0]       w_relock_count_nxt;
    logic [7:0]       w_timeout_count_nxt;

    // Next state, shared counter and registered-output decode.
    always_comb begin
        w_state_nxt         = r_state;
        w_cnt_nxt           = r_cnt + CNT_W'(1);
        w_relock_count_nxt  = r_relock_count;
        w_timeout_count_nxt = r_timeout_count;

        case (r_state)
            S_RESET_PLL: begin
                if (r_cnt == RST_LAST) w_state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (r_locked_s) begin
                    w_state_nxt = S_STABLE;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_state_nxt = S_RESET_PLL;
                    if (r_timeout_count != 8'hFF) w_timeout_count_nxt = r_timeout_count + 8'd1;
                end
            end
            S_STABLE: begin
                if (!r_locked_s)                w_state_nxt = S_WAIT_LOCK;
                else if (r_cnt == STABLE_LAST)  w_state_nxt = S_RUN;
            end
            S_RUN: begin
                // Lock loss wins over a coincident relock request so it is always counted.
                if (!r_locked_s) begin
                    w_state_nxt = S_RESET_PLL;
                    if (r_relock_count != 8'hFF) w_relock_count_nxt = r_relock_count + 8'd1;
                end else if (bus.relock_req) begin
                    w_state_nxt = S_RESET_PLL;
                end
            end
            default: w_state_nxt = S_RESET_PLL;
        endcase

        if (w_state_nxt != r_state) w_cnt_nxt = '0;

        w_pll_areset_nxt = (w_state_nxt == S_RESET_PLL);
        w_sys_reset_nxt  = (w_state_nxt != S_RUN);
        w_running_nxt    = (w_state_nxt == S_RUN);
    end

    // State, counter, lock synchroniser and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_RESET_PLL;
            r_cnt           <= '0;
            r_sync1         <= 1'b0;
            r_locked_s      <= 1'b0;
            r_pll_areset    <= 1'b1;
            r_sys_reset     <= 1'b1;
            r_running       <= 1'b0;
            r_relock_count  <= 8'd0;
            r_timeout_count <= 8'd0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_sync1         <= bus.pll_locked;
            r_locked_s      <= r_sync1;
            r_pll_areset    <= w_pll_areset_nxt;
            r_sys_reset     <= w_sys_reset_nxt;
            r_running       <= w_running_nxt;
            r_relock_count  <= w_relock_count_nxt;
            r_timeout_count <= w_timeout_count_nxt;
        end
    end

    assign bus.pll_areset    = r_pll_areset;
    assign bus.sys_reset     = r_sys_reset;
    assign bus.running       = r_running;
    assign bus.relock_count  = r_relock_count;
    assign bus.timeout_count = r_timeout_count;
endmodule
